// File: rtl/nibble_demux_rx_pkg.sv
// Shared types and helpers for the nibble demultiplexer receiver.
package nibble_demux_rx_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/nibble_demux_rx_timeout_ctr.sv
// Idle-gap counter: counts enabled cycles and pulses tc_o on the cycle that would reach MAX.
module nibble_timeout_ctr
   import nibble_demux_rx_pkg::*;
#(
   parameter int MAX = 255,
   localparam int CW = (clog2(MAX + 1) < 1) ? 1 : clog2(MAX + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic en_i,
   output logic tc_o
);

   logic [CW-1:0] cnt_q;

   assign tc_o = en_i && (cnt_q == CW'(MAX - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= tc_o ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/nibble_demux_rx.sv
// Reassembles index-tagged nibbles from the emulated 74-series mux bus into a
// full word, presented to the register side with a valid/ready handshake.
module nibble_demux_rx
   import nibble_demux_rx_pkg::*;
#(
   parameter int NIBBLES   = 2,
   parameter int LSB_FIRST = 1,
   parameter int TIMEOUT   = 255,
   localparam int IW = (clog2(NIBBLES) < 1) ? 1 : clog2(NIBBLES),
   localparam int W  = NIB_W * NIBBLES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable_n,
   input  logic [NIB_W-1:0] nib_in,
   input  logic [IW-1:0]    nib_idx,
   input  logic             nib_valid,
   output logic             nib_ready,
   output logic [W-1:0]     word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             error,
   output logic             busy
);

   localparam logic [IW-1:0] FIRST      = (LSB_FIRST != 0) ? IW'(0) : IW'(NIBBLES - 1);
   localparam logic [IW-1:0] LAST       = (LSB_FIRST != 0) ? IW'(NIBBLES - 1) : IW'(0);
   localparam logic [IW-1:0] FIRST_NEXT = (LSB_FIRST != 0) ? IW'(1) : IW'(NIBBLES - 2);

   state_e         state_q;
   logic [IW-1:0]  exp_q;
   logic [W-1:0]   asm_q;
   logic [W-1:0]   wordOut_q;
   logic           wordValid_q;
   logic           error_q;

   logic           accept;
   logic           tmoTc;
   logic [IW-1:0]  nextExp;
   logic [W-1:0]   freshWord;
   logic [W-1:0]   mergedWord;

   assign nib_ready  = (state_q != HOLD);
   assign busy       = (state_q == COLLECT);
   assign word_out   = wordOut_q;
   assign word_valid = wordValid_q;
   assign error      = error_q;

   assign accept  = nib_valid && nib_ready && !enable_n;
   assign nextExp = (LSB_FIRST != 0) ? exp_q + IW'(1) : exp_q - IW'(1);

   // freshWord starts a new word from this nibble alone; mergedWord adds it to the partial word
   always_comb begin
      freshWord  = '0;
      mergedWord = asm_q;
      for (int i = 0; i < NIBBLES; i++) begin
         if (nib_idx == IW'(i)) begin
            freshWord[NIB_W*i +: NIB_W]  = nib_in;
            mergedWord[NIB_W*i +: NIB_W] = nib_in;
         end
      end
   end

   generate
      if (TIMEOUT > 0) begin : gTimeout
         logic tmoClear;
         logic tmoEn;

         assign tmoClear = (state_q != COLLECT) || accept;
         assign tmoEn    = (state_q == COLLECT) && !accept && !enable_n;

         nibble_timeout_ctr #(.MAX(TIMEOUT)) uTimeout (
            .clk     (clk),
            .reset_n (reset_n),
            .clear_i (tmoClear),
            .en_i    (tmoEn),
            .tc_o    (tmoTc)
         );
      end else begin : gNoTimeout
         assign tmoTc = 1'b0;
      end
   endgenerate

   // In COLLECT the priority is enable_n abort, then accept, then timeout
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         exp_q       <= FIRST;
         asm_q       <= '0;
         wordOut_q   <= '0;
         wordValid_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (nib_idx == FIRST) begin
                     asm_q   <= freshWord;
                     exp_q   <= FIRST_NEXT;
                     state_q <= COLLECT;
                  end else begin
                     error_q <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (enable_n) begin
                  state_q <= IDLE;
                  asm_q   <= '0;
                  exp_q   <= FIRST;
               end else if (accept) begin
                  if (nib_idx == exp_q) begin
                     asm_q <= mergedWord;
                     if (exp_q == LAST) begin
                        wordOut_q   <= mergedWord;
                        wordValid_q <= 1'b1;
                        exp_q       <= FIRST;
                        state_q     <= HOLD;
                     end else begin
                        exp_q <= nextExp;
                     end
                  end else begin
                     error_q <= 1'b1;
                     if (nib_idx == FIRST) begin
                        asm_q <= freshWord;
                        exp_q <= FIRST_NEXT;
                     end else begin
                        state_q <= IDLE;
                        asm_q   <= '0;
                        exp_q   <= FIRST;
                     end
                  end
               end else if (tmoTc) begin
                  error_q <= 1'b1;
                  state_q <= IDLE;
                  asm_q   <= '0;
                  exp_q   <= FIRST;
               end
            end
            HOLD: begin
               if (word_ready) begin
                  wordValid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_demux_rx.sv
// Directed self-checking bench: dutA is 2 nibbles LSB-first with a short timeout,
// dutB is 4 nibbles MSB-first with the default timeout.
module tb_nibble_demux_rx;

   logic clk = 1'b0;
   logic rstN;

   logic       aEnableN, aValid, aReady;
   logic [3:0] aNib;
   logic       aIdx;
   logic       aNibReady, aWordValid, aError, aBusy;
   logic [7:0] aWord;

   logic        bEnableN, bValid, bReady;
   logic [3:0]  bNib;
   logic [1:0]  bIdx;
   logic        bNibReady, bWordValid, bError, bBusy;
   logic [15:0] bWord;

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   nibble_demux_rx #(.NIBBLES(2), .LSB_FIRST(1), .TIMEOUT(4)) dutA (
      .clk        (clk),
      .reset_n    (rstN),
      .enable_n   (aEnableN),
      .nib_in     (aNib),
      .nib_idx    (aIdx),
      .nib_valid  (aValid),
      .nib_ready  (aNibReady),
      .word_out   (aWord),
      .word_valid (aWordValid),
      .word_ready (aReady),
      .error      (aError),
      .busy       (aBusy)
   );

   nibble_demux_rx #(.NIBBLES(4), .LSB_FIRST(0), .TIMEOUT(255)) dutB (
      .clk        (clk),
      .reset_n    (rstN),
      .enable_n   (bEnableN),
      .nib_in     (bNib),
      .nib_idx    (bIdx),
      .nib_valid  (bValid),
      .nib_ready  (bNibReady),
      .word_out   (bWord),
      .word_valid (bWordValid),
      .word_ready (bReady),
      .error      (bError),
      .busy       (bBusy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input bit toB, input logic [1:0] idx, input logic [3:0] data);
      if (toB) begin
         bIdx   = idx;
         bNib   = data;
         bValid = 1'b1;
      end else begin
         aIdx   = idx[0];
         aNib   = data;
         aValid = 1'b1;
      end
      @(posedge clk);
      #1;
      aValid = 1'b0;
      bValid = 1'b0;
   endtask

   initial begin
      rstN = 1'b0;
      aEnableN = 1'b0; aValid = 1'b0; aReady = 1'b0; aNib = '0; aIdx = '0;
      bEnableN = 1'b0; bValid = 1'b0; bReady = 1'b0; bNib = '0; bIdx = '0;

      #12;
      checkOutput("rstWordA",   32'(aWord), 0);
      checkOutput("rstValidA",  32'(aWordValid), 0);
      checkOutput("rstErrorA",  32'(aError), 0);
      checkOutput("rstBusyA",   32'(aBusy), 0);
      checkOutput("rstReadyA",  32'(aNibReady), 1);
      checkOutput("rstWordB",   32'(bWord), 0);
      rstN = 1'b1;
      @(posedge clk);
      #1;

      // 4-nibble MSB-first word held until the consumer takes it
      applyStimulus(1, 2'd3, 4'h1);
      checkOutput("msbBusy", 32'(bBusy), 1);
      applyStimulus(1, 2'd2, 4'h2);
      applyStimulus(1, 2'd1, 4'h3);
      applyStimulus(1, 2'd0, 4'h4);
      checkOutput("msbValid", 32'(bWordValid), 1);
      checkOutput("msbWord",  32'(bWord), 'h1234);
      checkOutput("msbNibReadyLow", 32'(bNibReady), 0);
      waitCycles(1);
      checkOutput("msbHoldValid", 32'(bWordValid), 1);
      checkOutput("msbHoldNibReady", 32'(bNibReady), 0);
      bReady = 1'b1;
      waitCycles(1);
      checkOutput("msbReleaseValid", 32'(bWordValid), 0);
      checkOutput("msbReleaseNibReady", 32'(bNibReady), 1);
      checkOutput("msbReleaseBusy", 32'(bBusy), 0);
      bReady = 1'b0;

      // 2-nibble LSB-first word with word_ready held high
      aReady = 1'b1;
      applyStimulus(0, 2'd0, 4'hA);
      checkOutput("lsbBusy", 32'(aBusy), 1);
      checkOutput("lsbNoValidYet", 32'(aWordValid), 0);
      applyStimulus(0, 2'd1, 4'h5);
      checkOutput("lsbValid", 32'(aWordValid), 1);
      checkOutput("lsbWord",  32'(aWord), 'h5A);
      waitCycles(1);
      checkOutput("lsbValidOneCycle", 32'(aWordValid), 0);
      checkOutput("lsbNibReady", 32'(aNibReady), 1);

      // Wrong first index in IDLE, then a restart inside COLLECT
      applyStimulus(0, 2'd1, 4'h0);
      checkOutput("idleMismatchError", 32'(aError), 1);
      checkOutput("idleMismatchBusy",  32'(aBusy), 0);
      waitCycles(1);
      checkOutput("idleMismatchPulse", 32'(aError), 0);
      checkOutput("idleMismatchNoWord", 32'(aWordValid), 0);
      applyStimulus(0, 2'd0, 4'h3);
      checkOutput("restartFirstNoError", 32'(aError), 0);
      applyStimulus(0, 2'd0, 4'h7);
      checkOutput("restartError", 32'(aError), 1);
      checkOutput("restartBusy",  32'(aBusy), 1);
      applyStimulus(0, 2'd1, 4'hC);
      checkOutput("restartErrorCleared", 32'(aError), 0);
      checkOutput("restartValid", 32'(aWordValid), 1);
      checkOutput("restartWord",  32'(aWord), 'hC7);
      waitCycles(1);

      // Timeout after four idle cycles inside a word
      applyStimulus(0, 2'd0, 4'h9);
      waitCycles(3);
      checkOutput("tmoNotYetError", 32'(aError), 0);
      checkOutput("tmoNotYetBusy",  32'(aBusy), 1);
      waitCycles(1);
      checkOutput("tmoError", 32'(aError), 1);
      checkOutput("tmoBusy",  32'(aBusy), 0);
      applyStimulus(0, 2'd1, 4'h1);
      checkOutput("tmoThenMismatchError", 32'(aError), 1);
      checkOutput("tmoThenMismatchNoWord", 32'(aWordValid), 0);

      // enable_n aborts silently mid-word and is ignored while a word is held
      aReady = 1'b0;
      applyStimulus(0, 2'd0, 4'h3);
      aEnableN = 1'b1;
      waitCycles(1);
      checkOutput("abortBusy",  32'(aBusy), 0);
      checkOutput("abortError", 32'(aError), 0);
      aEnableN = 1'b0;
      applyStimulus(0, 2'd0, 4'hE);
      applyStimulus(0, 2'd1, 4'hE);
      checkOutput("abortWordValid", 32'(aWordValid), 1);
      checkOutput("abortWord",      32'(aWord), 'hEE);
      checkOutput("abortNoError",   32'(aError), 0);
      aEnableN = 1'b1;
      aValid = 1'b1; aIdx = 1'b0; aNib = 4'hF;
      waitCycles(2);
      checkOutput("holdIgnoresEnableValid", 32'(aWordValid), 1);
      checkOutput("holdIgnoresEnableWord",  32'(aWord), 'hEE);
      aValid = 1'b0;
      aEnableN = 1'b0;
      aReady = 1'b1;
      waitCycles(1);
      checkOutput("holdReleaseValid", 32'(aWordValid), 0);
      checkOutput("wordKeepsValue",   32'(aWord), 'hEE);
      aReady = 1'b0;

      // Asynchronous reset during COLLECT
      applyStimulus(0, 2'd0, 4'h1);
      #1 rstN = 1'b0;
      #1;
      checkOutput("rstCollectBusy",  32'(aBusy), 0);
      checkOutput("rstCollectValid", 32'(aWordValid), 0);
      checkOutput("rstCollectError", 32'(aError), 0);
      checkOutput("rstCollectWord",  32'(aWord), 0);
      rstN = 1'b1;
      @(posedge clk);
      #1;

      // Asynchronous reset during HOLD
      applyStimulus(0, 2'd0, 4'h2);
      applyStimulus(0, 2'd1, 4'h4);
      checkOutput("preRstHoldWord", 32'(aWord), 'h42);
      #1 rstN = 1'b0;
      #1;
      checkOutput("rstHoldValid",    32'(aWordValid), 0);
      checkOutput("rstHoldWord",     32'(aWord), 0);
      checkOutput("rstHoldNibReady", 32'(aNibReady), 1);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      aReady = 1'b1;
      applyStimulus(0, 2'd0, 4'h6);
      applyStimulus(0, 2'd1, 4'h8);
      checkOutput("postRstValid", 32'(aWordValid), 1);
      checkOutput("postRstWord",  32'(aWord), 'h86);
      waitCycles(1);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
